// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan sequencer and its producer/consumer.
// The sequencer takes the slave side; whoever drives start/ack and the mux takes the master side.
interface mux_scan_ctrl_if;
  logic       start;
  logic       continuous;
  logic       y_in;
  logic       ack;
  logic       s0;
  logic       s1;
  logic [3:0] snapshot;
  logic       valid;
  logic       busy;

  modport master (
    output start, continuous, y_in, ack,
    input  s0, s1, snapshot, valid, busy
  );

  modport slave (
    input  start, continuous, y_in, ack,
    output s0, s1, snapshot, valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux through channels 0..3, samples y after a settle delay,
// and hands the assembled 4-bit snapshot out through a valid/ack handshake.
module mux_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = $clog2(DWELL)
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DWELL - 1);

  state_t             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [3:0]         snap_q, snap_d;
  logic               valid_q, valid_d;
  logic [1:0]         sel_q, sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (cnt_q == SETTLE_C) shadow_d[ch_q] = bus.y_in;
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (ch_q == 2'd3) begin
            // SETTLE <= DWELL-2 guarantees channel 3 is already in shadow_q here
            snap_d  = shadow_q;
            valid_d = 1'b1;
            ch_d    = '0;
            state_d = DONE;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.ack) begin
          valid_d = 1'b0;
          if (bus.continuous) begin
            state_d  = SCAN;
            ch_d     = '0;
            cnt_d    = '0;
            shadow_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selects are registered off next state so they change on the same edge as ch
  assign sel_d = (state_d == SCAN) ? ch_d : 2'b00;

  assign bus.s0       = sel_q[0];
  assign bus.s1       = sel_q[1];
  assign bus.snapshot = snap_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
